// File: rtl/vga_rx_monitor.sv
// TinyVGA PMOD receive monitor: measures line/frame timing and tracks lock.
// Define VGA_RX_CHECKSUM_EN to enable the per-frame pixel checksum.
module vga_rx_monitor #(
    parameter int H_TOTAL_EXP = 800,
    parameter int V_TOTAL_EXP = 525,
    parameter int LOCK_FRAMES = 2,
    parameter int WDT_W       = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pmod_in,
    output logic        locked,
    output logic        lock_lost,
    output logic        frame_done,
    output logic [9:0]  h_total,
    output logic [9:0]  v_total,
    output logic [15:0] frame_sum
);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [9:0] H_EXP  = 10'(H_TOTAL_EXP);
    localparam logic [9:0] V_EXP  = 10'(V_TOTAL_EXP);
    localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [9:0] CNT_MAX = 10'h3FF;

    logic [7:0]       pmod_q, pmod_d;
    logic             hs_prev_q, hs_prev_d;
    logic             vs_prev_q, vs_prev_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic             h_seen_q, h_seen_d;
    logic             line_bad_q, line_bad_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [WDT_W-1:0] wd_q, wd_d;
    logic [1:0]       state_q, state_d;
    logic             frame_done_q, frame_done_d;
    logic             lock_lost_q, lock_lost_d;
    logic [9:0]       h_total_q, h_total_d;
    logic [9:0]       v_total_q, v_total_d;

    logic       hs, vs, hs_edge, vs_edge, active;
    logic       h_upd, h_bad, frame_good, timeout;
    logic [9:0] h_meas, v_meas;
    logic [3:0] good_inc;

    assign hs      = pmod_q[7];
    assign vs      = pmod_q[3];
    assign hs_edge = hs_prev_q & ~hs;
    assign vs_edge = vs_prev_q & ~vs;
    assign active  = (state_q != S_SEARCH);

    assign h_meas = (h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + 10'd1;
    assign h_upd  = hs_edge & active & h_seen_q;
    assign h_bad  = h_upd & (h_meas != H_EXP);

    // A line that ends on the vsync edge belongs to the frame that ends there.
    assign v_meas = (hs_edge && v_cnt_q != CNT_MAX) ? v_cnt_q + 10'd1 : v_cnt_q;
    assign frame_good = ~(line_bad_q | h_bad) & (v_meas == V_EXP);
    assign good_inc   = good_cnt_q + 4'd1;
    assign timeout    = active & (&wd_q) & ~vs_edge;

    always_comb begin
        pmod_d       = pmod_in;
        hs_prev_d    = hs;
        vs_prev_d    = vs;
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        h_seen_d     = h_seen_q;
        line_bad_d   = line_bad_q;
        good_cnt_d   = good_cnt_q;
        wd_d         = (&wd_q) ? wd_q : wd_q + 1'b1;
        state_d      = state_q;
        frame_done_d = 1'b0;
        lock_lost_d  = 1'b0;
        h_total_d    = h_total_q;
        v_total_d    = v_total_q;

        if (hs_edge) begin
            h_cnt_d = '0;
        end else if (h_cnt_q != CNT_MAX) begin
            h_cnt_d = h_cnt_q + 10'd1;
        end
        if (hs_edge && v_cnt_q != CNT_MAX) begin
            v_cnt_d = v_cnt_q + 10'd1;
        end

        if (!active) begin
            h_seen_d = 1'b0;
        end else if (hs_edge) begin
            h_seen_d = 1'b1;
        end
        if (h_upd) begin
            h_total_d = h_meas;
        end
        if (h_bad) begin
            line_bad_d = 1'b1;
        end

        if (vs_edge) begin
            v_total_d  = v_meas;
            v_cnt_d    = '0;
            line_bad_d = 1'b0;
            wd_d       = '0;
            unique case (state_q)
                S_SEARCH: begin
                    state_d    = S_CHECK;
                    good_cnt_d = '0;
                end
                S_CHECK: begin
                    frame_done_d = 1'b1;
                    if (frame_good) begin
                        good_cnt_d = good_inc;
                        if (good_inc == LOCK_N) begin
                            state_d = S_LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                S_LOCKED: begin
                    frame_done_d = 1'b1;
                    if (!frame_good) begin
                        state_d     = S_CHECK;
                        good_cnt_d  = '0;
                        lock_lost_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = S_SEARCH;
                    good_cnt_d = '0;
                end
            endcase
        end else if (timeout) begin
            state_d     = S_SEARCH;
            lock_lost_d = (state_q == S_LOCKED);
            h_cnt_d     = '0;
            v_cnt_d     = '0;
            wd_d        = '0;
            good_cnt_d  = '0;
            line_bad_d  = 1'b0;
            h_seen_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmod_q       <= 8'hFF;
            hs_prev_q    <= 1'b1;
            vs_prev_q    <= 1'b1;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            h_seen_q     <= 1'b0;
            line_bad_q   <= 1'b0;
            good_cnt_q   <= '0;
            wd_q         <= '0;
            state_q      <= S_SEARCH;
            frame_done_q <= 1'b0;
            lock_lost_q  <= 1'b0;
            h_total_q    <= '0;
            v_total_q    <= '0;
        end else begin
            pmod_q       <= pmod_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            h_seen_q     <= h_seen_d;
            line_bad_q   <= line_bad_d;
            good_cnt_q   <= good_cnt_d;
            wd_q         <= wd_d;
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
            lock_lost_q  <= lock_lost_d;
            h_total_q    <= h_total_d;
            v_total_q    <= v_total_d;
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [5:0]  pix;
    logic [15:0] acc_q, acc_d, acc_sum;
    logic [15:0] frame_sum_q, frame_sum_d;

    // Pixel order is {R1,R0,G1,G0,B1,B0}.
    assign pix     = {pmod_q[0], pmod_q[4], pmod_q[1],
                      pmod_q[5], pmod_q[2], pmod_q[6]};
    assign acc_sum = acc_q + {10'd0, pix};

    always_comb begin
        acc_d       = acc_sum;
        frame_sum_d = frame_sum_q;
        if (!active || timeout) begin
            acc_d = '0;
        end else if (vs_edge) begin
            frame_sum_d = acc_sum;
            acc_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            frame_sum_q <= '0;
        end else begin
            acc_q       <= acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign frame_sum = frame_sum_q;
`else
    assign frame_sum = '0;
`endif

    assign locked     = (state_q == S_LOCKED);
    assign lock_lost  = lock_lost_q;
    assign frame_done = frame_done_q;
    assign h_total    = h_total_q;
    assign v_total    = v_total_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor: generated small-format video frames against
// a frame-level model of lock tracking, timing measurement and checksum.
module tb_vga_rx_monitor;

    localparam int H      = 40;
    localparam int V      = 20;
    localparam int LOCKN  = 2;
    localparam int WW     = 12;
    localparam int WD_LIM = (1 << WW) + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pmod_in = 8'hFF;
    logic        locked, lock_lost, frame_done;
    logic [9:0]  h_total, v_total;
    logic [15:0] frame_sum;

    vga_rx_monitor #(
        .H_TOTAL_EXP(H),
        .V_TOTAL_EXP(V),
        .LOCK_FRAMES(LOCKN),
        .WDT_W(WW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pmod_in(pmod_in),
        .locked(locked),
        .lock_lost(lock_lost),
        .frame_done(frame_done),
        .h_total(h_total),
        .v_total(v_total),
        .frame_sum(frame_sum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model of the receiver, frame granularity
    bit m_synced = 0;
    bit m_locked = 0;
    int good_run = 0;
    int since    = 0;
    int cd       = 0;
    bit p_done, p_lost, p_locked;
    int p_h, p_v, p_sum;
    int f_lines, f_last, f_sum;
    bit f_ok;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] enc(bit hs, bit vs, logic [5:0] p);
        return {hs, p[0], p[2], p[4], vs, p[1], p[3], p[5]};
    endfunction

    task automatic frame_end();
        bit good;
        if (!m_synced) begin
            m_synced = 1;
            good_run = 0;
            p_done   = 0;
            p_lost   = 0;
            p_locked = m_locked;
        end else begin
            good   = f_ok && (f_lines == V);
            p_done = 1;
            p_h    = f_last;
            p_v    = f_lines;
            p_sum  = f_sum % 65536;
            if (good) begin
                good_run++;
                p_locked = m_locked || (good_run >= LOCKN);
                p_lost   = 0;
            end else begin
                p_lost   = m_locked;
                p_locked = 0;
                good_run = 0;
            end
        end
        cd = 2;
    endtask

    task automatic drive(input logic [7:0] v, input bit vs_fall);
        bit fd_exp, ll_exp;
        int sum_exp;
        @(negedge clk);
        since++;
        fd_exp = 0;
        ll_exp = 0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                m_locked = p_locked;
                fd_exp   = p_done;
                ll_exp   = p_lost;
                if (p_done) begin
`ifdef VGA_RX_CHECKSUM_EN
                    sum_exp = p_sum;
`else
                    sum_exp = 0;
`endif
                    chk("h_total", 32'(h_total), 32'(p_h));
                    chk("v_total", 32'(v_total), 32'(p_v));
                    chk("frame_sum", 32'(frame_sum), 32'(sum_exp));
                end
            end
        end
        if (m_synced && since == WD_LIM) begin
            ll_exp   = m_locked;
            m_locked = 0;
            m_synced = 0;
            good_run = 0;
        end
        chk("locked", 32'(locked), 32'(m_locked));
        chk("frame_done", 32'(frame_done), 32'(fd_exp));
        chk("lock_lost", 32'(lock_lost), 32'(ll_exp));
        pmod_in = v;
        if (vs_fall) begin
            frame_end();
            since = 0;
        end
    endtask

    task automatic send_frame(input int lines, input int bad_ln,
                              input int bad_len, input bit solid);
        int len;
        bit act, first;
        logic [5:0] p;
        for (int l = 0; l < lines; l++) begin
            len = (l == bad_ln) ? bad_len : H;
            for (int c = 0; c < len; c++) begin
                act   = (l >= 2) && (l < 18) && (c >= 8) && (c < 32);
                p     = act ? (solid ? 6'h3F : 6'($urandom)) : 6'h00;
                first = (l == 0) && (c == 0);
                drive(enc(c >= 4, l >= 2, p), first);
                if (first) begin
                    f_lines = lines;
                    f_ok    = 1;
                    f_sum   = 0;
                end
                f_sum += int'(p);
            end
            if (len != H) f_ok = 0;
            f_last = len;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_locked"}, 32'(locked), 0);
        chk({tag, "_lock_lost"}, 32'(lock_lost), 0);
        chk({tag, "_frame_done"}, 32'(frame_done), 0);
        chk({tag, "_h_total"}, 32'(h_total), 0);
        chk({tag, "_v_total"}, 32'(v_total), 0);
        chk({tag, "_frame_sum"}, 32'(frame_sum), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        pmod_in = 8'hFF;
        #1;
        check_zero("rst");
        m_synced = 0;
        m_locked = 0;
        good_run = 0;
        cd       = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        since = 0;
    endtask

    initial begin
        #1;
        check_zero("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) drive(8'hFF, 0);

        // initial lock, first frame solid white
        send_frame(V, -1, H, 1);
        repeat (3) send_frame(V, -1, H, 0);

        // one long line while locked, then relock
        send_frame(V, 5, H + 1, 0);
        repeat (3) send_frame(V, -1, H, 0);

        // short line that ends on the vsync edge
        send_frame(V, V - 1, H - 1, 0);
        repeat (3) send_frame(V, -1, H, 0);

        // one line short per frame: never locks
        repeat (4) send_frame(V - 1, -1, H, 0);

        // relock, then syncs stuck idle until the watchdog fires
        repeat (4) send_frame(V, -1, H, 0);
        repeat (4200) drive(8'hFF, 0);

        // resync, then reset in the middle of a locked frame
        repeat (5) send_frame(V, -1, H, 0);
        chk("locked_before_reset", 32'(locked), 1);
        do_reset();

        repeat (5) send_frame(V, -1, H, 0);
        chk("relocked_after_reset", 32'(locked), 1);
        repeat (5) drive(8'hFF, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_rx_monitor.md
VGA_RX_MONITOR -- requirements
Module: vga_rx_monitor

Interface
REQ-001 Parameter H_TOTAL_EXP, default 800, expected clocks per line.
REQ-002 Parameter V_TOTAL_EXP, default 525, expected lines per frame.
REQ-003 Parameter LOCK_FRAMES, default 2, consecutive good frames needed for lock (range 1..15).
REQ-004 clk  input  1  pixel clock; the block's only clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 pmod_in  input  8  TinyVGA PMOD byte {hsync, B[0], G[0], R[0], vsync, B[1], G[1], R[1]}, bit 7 first.
REQ-007 locked  output  1  high while in LOCKED.
REQ-008 lock_lost  output  1  one-cycle pulse on LOCKED->CHECK or LOCKED->SEARCH.
REQ-009 frame_done  output  1  one-cycle pulse per measured frame end.
REQ-010 h_total  output  10  last measured line length in clocks.
REQ-011 v_total  output  10  last measured frame length in lines.
REQ-012 frame_sum  output  16  pixel checksum of last complete frame.

Function
REQ-013 pmod_in SHALL be registered once; all decoding uses the registered copy (1-cycle input latency).
REQ-014 hsync and vsync are active-low; a line starts on an hsync falling edge; a frame starts on a vsync falling edge (edge = previous registered 1, current registered 0).
REQ-015 Pixel value SHALL be the 6-bit {R[1],R[0],G[1],G[0],B[1],B[0]}.
REQ-016 h_cnt: cleared to 0 on an hsync edge, else +1, saturating at 1023.
REQ-017 On each hsync edge after the first since leaving SEARCH, h_total <= h_cnt+1 (saturates at 1023); line_bad sticky flag set if that value != H_TOTAL_EXP.
REQ-018 v_cnt counts hsync edges since last vsync edge, saturating at 1023; a coincident hsync edge counts toward the ending frame.
REQ-019 On a vsync edge: v_total <= v_cnt (+1 if coincident hsync edge), v_cnt <= 0, line_bad cleared.
REQ-020 FSM states SEARCH, CHECK, LOCKED.
REQ-021 SEARCH -> CHECK on first vsync edge; no frame_done, good_cnt <= 0.
REQ-022 In CHECK/LOCKED each vsync edge SHALL pulse frame_done; frame good iff line_bad clear (incl. coincident line) and v_total == V_TOTAL_EXP.
REQ-023 CHECK: good frame -> good_cnt+1, enter LOCKED when good_cnt+1 == LOCK_FRAMES; bad frame -> good_cnt <= 0, stay CHECK.
REQ-024 LOCKED: good frame -> stay; bad frame -> CHECK, good_cnt <= 0, lock_lost pulse.
REQ-025 Watchdog: 20-bit frame timer cleared on vsync edge; reaching 2^20-1 in CHECK/LOCKED -> SEARCH (lock_lost if from LOCKED), all counters cleared.
REQ-026 locked SHALL change in the cycle after the deciding vsync edge, together with frame_done.

Reset
REQ-027 rst_n low SHALL asynchronously force state SEARCH, all counters, flags, input register (to 0xFF sync-idle) and outputs to 0; reset mid-frame discards the partial frame.
REQ-028 After rst_n release, no frame_done before the second vsync edge.

Configuration
REQ-029 Macro VGA_RX_CHECKSUM_EN defined: 16-bit wrapping accumulator adds pixel value every clock in CHECK/LOCKED; on vsync edge frame_sum <= accumulator (incl. current pixel), accumulator <= 0.
REQ-030 VGA_RX_CHECKSUM_EN undefined: accumulator absent, frame_sum constant 0; all other behaviour identical.

Verification
REQ-031 Standard 800x525 stream, LOCK_FRAMES=2 -> frame_done at frames 2,3; locked rises with second frame_done; h_total=800, v_total=525.
REQ-032 Locked, one line of 801 clocks -> next frame_done with locked=0, lock_lost=1 for one cycle; relock after 2 good frames.
REQ-033 Stream with 524 lines -> v_total=524, never locked.
REQ-034 Solid colour 0x3F over 640x480 active area, checksum on -> frame_sum = (307200*63) mod 65536 = 20480; checksum off -> 0.
REQ-035 Syncs stuck high 2^20 clocks while locked -> locked=0, lock_lost pulse, state SEARCH.
REQ-036 rst_n asserted mid-frame while locked -> outputs 0 immediately; after release locked again after 1 sync frame + 2 good frames.
